// File: rtl/matcher_result_collector_pkg.sv
// Shared types and constants for the matcher result collection path.
package matcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } rc_state_e;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_TAG_WIDTH  = 16;
  localparam int REC_WIDTH      = DEF_TAG_WIDTH + DEF_DATA_WIDTH;
  localparam int CNT_WIDTH      = 32;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/matcher_result_fifo.sv
// First-word fall-through FIFO; full/empty derive from registered pointers so
// a same-cycle pop never makes room for a same-cycle push.
module matcher_result_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/matcher_result_collector.sv
// Collects matcher results into a tagged FWFT FIFO, sequences the result_reset
// handshake and keeps match / no-match / stall statistics.
module matcher_result_collector
  import matcher_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLR_TIMEOUT = 255
) (
  input  logic                            fclk,
  input  logic                            areset_n,
  input  logic                            in_data_valid,
  input  logic                            result_match,
  input  logic                            result_valid,
  input  logic [DATA_WIDTH-1:0]           result_data,
  output logic                            result_reset,
  output logic                            rd_valid,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] rd_data,
  input  logic                            rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            match_count,
  output logic [CNT_WIDTH-1:0]            nomatch_count,
  output logic [CNT_WIDTH-1:0]            stall_count,
  output logic                            err_stuck,
  input  logic                            clr_stats
);

  localparam int RecW = TAG_WIDTH + DATA_WIDTH;
  localparam int TmoW = $clog2(CLR_TIMEOUT + 1);

  rc_state_e              state_q, state_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [TAG_WIDTH-1:0]   win_idx_q, win_idx_d, tag;
  logic                   ack_q;
  logic [CNT_WIDTH-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0]   nomatch_cnt_q, nomatch_cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic                   err_q, err_d;
  logic                   push, inc_match, inc_nomatch, inc_stall, set_err;
  logic                   fifo_full, fifo_empty;

  // Tag names the last accepted beat, i.e. the index before any same-cycle beat.
  assign tag       = win_idx_q - TAG_WIDTH'(1);
  assign win_idx_d = in_data_valid ? win_idx_q + TAG_WIDTH'(1) : win_idx_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    push        = 1'b0;
    inc_match   = 1'b0;
    inc_nomatch = 1'b0;
    inc_stall   = 1'b0;
    set_err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (result_match) begin
          if (!fifo_full) begin
            push      = 1'b1;
            inc_match = 1'b1;
            state_d   = ST_ACK;
          end else begin
            inc_stall = 1'b1;
          end
        end else if (result_valid) begin
          inc_nomatch = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_CLR;
        tmo_d   = '0;
      end
      ST_WAIT_CLR: begin
        if (!result_match) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TmoW'(CLR_TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear request overrides any increment landing in the same cycle.
  always_comb begin
    match_cnt_d   = match_cnt_q;
    nomatch_cnt_d = nomatch_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    err_d         = err_q;
    if (clr_stats) begin
      match_cnt_d   = '0;
      nomatch_cnt_d = '0;
      stall_cnt_d   = '0;
      err_d         = 1'b0;
    end else begin
      if (inc_match)   match_cnt_d   = sat_inc(match_cnt_q);
      if (inc_nomatch) nomatch_cnt_d = sat_inc(nomatch_cnt_q);
      if (inc_stall)   stall_cnt_d   = sat_inc(stall_cnt_q);
      err_d = err_q | set_err;
    end
  end

  always_ff @(posedge fclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      win_idx_q     <= '0;
      ack_q         <= 1'b0;
      match_cnt_q   <= '0;
      nomatch_cnt_q <= '0;
      stall_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      win_idx_q     <= win_idx_d;
      ack_q         <= push;
      match_cnt_q   <= match_cnt_d;
      nomatch_cnt_q <= nomatch_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      err_q         <= err_d;
    end
  end

  matcher_result_fifo #(
    .WIDTH(RecW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (fclk),
    .rst_ni  (areset_n),
    .push_i  (push),
    .pop_i   (rd_ready),
    .wdata_i ({tag, result_data}),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rd_valid      = !fifo_empty;
  assign result_reset  = ack_q;
  assign match_count   = match_cnt_q;
  assign nomatch_count = nomatch_cnt_q;
  assign stall_count   = stall_cnt_q;
  assign err_stuck     = err_q;

endmodule

// File: tb/tb_matcher_result_collector.sv
// Bench for matcher_result_collector: emulated matcher, queue-based reference
// model, directed scenarios followed by a randomized soak.
module tb_matcher_result_collector;

  localparam int DW    = 64;
  localparam int TW    = 16;
  localparam int DEPTH = 16;
  localparam int TMO   = 255;

  logic          fclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          in_data_valid = 1'b0;
  logic          result_match = 1'b0;
  logic          result_valid = 1'b0;
  logic [DW-1:0] result_data = '0;
  logic          rd_ready = 1'b0;
  logic          clr_stats = 1'b0;
  logic          result_reset, rd_valid, err_stuck;
  logic [TW+DW-1:0] rd_data;
  logic [4:0]    fifo_level;
  logic [31:0]   match_count, nomatch_count, stall_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: occupancy as a queue, handshake as phase flags.
  logic [TW+DW-1:0] mFifo[$];
  logic [TW-1:0]    mWin;
  bit               mAckOut, mWaiting, mErr;
  int               mWaitCnt;
  logic [31:0]      mMatch, mNomatch, mStall;

  bit               pending, holdThroughAck, popEnable;
  int               cool;

  always #5 fclk = ~fclk;

  matcher_result_collector #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH), .CLR_TIMEOUT(TMO)
  ) dut (
    .fclk(fclk), .areset_n(areset_n), .in_data_valid(in_data_valid),
    .result_match(result_match), .result_valid(result_valid), .result_data(result_data),
    .result_reset(result_reset), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .fifo_level(fifo_level), .match_count(match_count), .nomatch_count(nomatch_count),
    .stall_count(stall_count), .err_stuck(err_stuck), .clr_stats(clr_stats)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    mWin = '0; mAckOut = 0; mWaiting = 0; mErr = 0; mWaitCnt = 0;
    mMatch = '0; mNomatch = '0; mStall = '0;
  endtask

  task automatic modelStep();
    bit full, popNow, pushNow, ackNext, incM, incN, incS, errSet;
    full = (mFifo.size() == DEPTH);
    popNow = rd_ready && (mFifo.size() != 0);
    pushNow = 0; ackNext = 0; incM = 0; incN = 0; incS = 0; errSet = 0;
    if (mAckOut) begin
      mWaiting = 1; mWaitCnt = 0;
    end else if (mWaiting) begin
      if (!result_match) mWaiting = 0;
      else begin
        mWaitCnt++;
        if (mWaitCnt == TMO) begin mWaiting = 0; errSet = 1; end
      end
    end else if (result_match) begin
      if (!full) begin pushNow = 1; incM = 1; ackNext = 1; end
      else incS = 1;
    end else if (result_valid) begin
      incN = 1;
    end
    if (popNow) void'(mFifo.pop_front());
    if (pushNow) mFifo.push_back({mWin - 16'd1, result_data});
    mWin = mWin + 16'(in_data_valid);
    mAckOut = ackNext;
    if (clr_stats) begin
      mMatch = '0; mNomatch = '0; mStall = '0; mErr = 0;
    end else begin
      if (incM && mMatch != 32'hFFFF_FFFF) mMatch++;
      if (incN && mNomatch != 32'hFFFF_FFFF) mNomatch++;
      if (incS && mStall != 32'hFFFF_FFFF) mStall++;
      if (errSet) mErr = 1;
    end
  endtask

  task automatic compareAll();
    checkOutput("result_reset", 128'(result_reset), 128'(mAckOut));
    checkOutput("rd_valid", 128'(rd_valid), 128'(mFifo.size() != 0));
    checkOutput("rd_data", 128'(rd_data), (mFifo.size() != 0) ? 128'(mFifo[0]) : 128'd0);
    checkOutput("fifo_level", 128'(fifo_level), 128'(mFifo.size()));
    checkOutput("match_count", 128'(match_count), 128'(mMatch));
    checkOutput("nomatch_count", 128'(nomatch_count), 128'(mNomatch));
    checkOutput("stall_count", 128'(stall_count), 128'(mStall));
    checkOutput("err_stuck", 128'(err_stuck), 128'(mErr));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic applyStimulus(input bit beat, input bit done, input bit clr);
    in_data_valid = beat;
    result_match  = pending;
    result_valid  = pending | done;
    rd_ready      = popEnable;
    clr_stats     = clr;
    @(posedge fclk);
    modelStep();
    @(negedge fclk);
    compareAll();
    if (result_reset) begin
      if (!holdThroughAck) pending = 0;
      cool = 2;
    end else if (cool > 0) begin
      cool--;
    end
  endtask

  task automatic raiseMatch(input logic [DW-1:0] d);
    pending = 1;
    result_data = d;
  endtask

  task automatic matchAndAck(input logic [DW-1:0] d, input int budget, output bit got);
    got = 0;
    raiseMatch(d);
    for (int i = 0; i < budget && !got; i++) begin
      applyStimulus(0, 0, 0);
      if (result_reset) got = 1;
    end
    while (cool > 0) applyStimulus(0, 0, 0);
  endtask

  task automatic resetDut();
    areset_n = 0;
    pending = 0; holdThroughAck = 0; popEnable = 0; cool = 0;
    in_data_valid = 0; result_match = 0; result_valid = 0; rd_ready = 0; clr_stats = 0;
    modelReset();
    repeat (2) @(negedge fclk);
    compareAll();
    areset_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    int acks, errCycle;

    // Tag of a match after three beats, acknowledge latency.
    resetDut();
    repeat (3) applyStimulus(1, 0, 0);
    raiseMatch(64'hDEAD_BEEF_0000_0001);
    applyStimulus(0, 0, 0);
    checkOutput("t1_ack_next_cycle", 128'(result_reset), 128'd1);
    checkOutput("t1_rd_data", 128'(rd_data), 128'({16'd2, 64'hDEAD_BEEF_0000_0001}));
    checkOutput("t1_match_count", 128'(match_count), 128'd1);
    applyStimulus(0, 0, 0);
    checkOutput("t1_ack_one_cycle", 128'(result_reset), 128'd0);

    // Window-done pulses without a match.
    resetDut();
    acks = 0;
    repeat (5) begin
      applyStimulus(0, 1, 0);
      acks += int'(result_reset);
      applyStimulus(0, 0, 0);
      acks += int'(result_reset);
    end
    checkOutput("t2_nomatch", 128'(nomatch_count), 128'd5);
    checkOutput("t2_no_ack", 128'(acks), 128'd0);
    checkOutput("t2_empty", 128'(rd_valid), 128'd0);

    // Fill to depth, stall the 17th, then free one slot.
    resetDut();
    for (int i = 0; i < 16; i++) begin
      matchAndAck({$urandom, $urandom}, 8, got);
      checkOutput("t3_ack", 128'(got), 128'd1);
    end
    raiseMatch({$urandom, $urandom});
    acks = 0;
    repeat (10) begin
      applyStimulus(0, 0, 0);
      acks += int'(result_reset);
    end
    checkOutput("t3_held", 128'(acks), 128'd0);
    checkOutput("t3_stall", 128'(stall_count), 128'd10);
    checkOutput("t3_full_level", 128'(fifo_level), 128'd16);
    popEnable = 1;
    applyStimulus(0, 0, 0);
    popEnable = 0;
    checkOutput("t3_no_bypass", 128'(result_reset), 128'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_accept", 128'(result_reset), 128'd1);
    checkOutput("t3_level", 128'(fifo_level), 128'd16);
    checkOutput("t3_stall_final", 128'(stall_count), 128'd11);
    while (cool > 0) applyStimulus(0, 0, 0);

    // Stuck match: timeout, re-accept, then clear statistics.
    resetDut();
    holdThroughAck = 1;
    errCycle = -1;
    raiseMatch(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 302; i++) begin
      applyStimulus(0, 0, 0);
      if (err_stuck && errCycle < 0) errCycle = i;
    end
    pending = 0;
    holdThroughAck = 0;
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("t4_err_cycle", 128'(errCycle), 128'd256);
    checkOutput("t4_err", 128'(err_stuck), 128'd1);
    checkOutput("t4_level", 128'(fifo_level), 128'd2);
    checkOutput("t4_match_count", 128'(match_count), 128'd2);
    applyStimulus(0, 1, 1);
    checkOutput("t4_clr_err", 128'(err_stuck), 128'd0);
    checkOutput("t4_clr_match", 128'(match_count), 128'd0);
    checkOutput("t4_clr_wins", 128'(nomatch_count), 128'd0);
    checkOutput("t4_clr_level", 128'(fifo_level), 128'd2);

    // Asynchronous reset while acknowledging with entries queued.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      matchAndAck({$urandom, $urandom}, 8, got);
      checkOutput("t5_fill_ack", 128'(got), 128'd1);
    end
    raiseMatch({$urandom, $urandom});
    applyStimulus(1, 0, 0);
    checkOutput("t5_in_ack", 128'(result_reset), 128'd1);
    #2 areset_n = 0;
    #1;
    checkOutput("t5_rst_ack", 128'(result_reset), 128'd0);
    checkOutput("t5_rst_level", 128'(fifo_level), 128'd0);
    checkOutput("t5_rst_valid", 128'(rd_valid), 128'd0);
    modelReset();
    pending = 0; cool = 0;
    @(negedge fclk);
    areset_n = 1;
    applyStimulus(1, 0, 0);
    matchAndAck(64'hCAFE, 8, got);
    checkOutput("t5_post_ack", 128'(got), 128'd1);
    checkOutput("t5_tag_restart", 128'(rd_data[TW+DW-1:DW]), 128'd0);

    // Randomized soak against the model.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      bit beat, done, clr;
      beat = ($urandom_range(1, 0) == 1);
      done = !pending && ($urandom_range(3, 0) == 0);
      clr  = ($urandom_range(199, 0) == 0);
      popEnable = ($urandom_range(3, 0) != 0) ^ ((c / 400) % 2 == 1);
      if (!pending && cool == 0 && $urandom_range(2, 0) == 0)
        raiseMatch({$urandom, $urandom});
      applyStimulus(beat, done, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
